// File: rtl/div_ratio_checker.sv
// Monitors a divided clock: measures period and high time in clk cycles, checks them against DIV.
// Optional duty-cycle checking is enabled by defining DUTY_CHECK_EN.
module div_ratio_checker #(
    parameter int DIV      = 12,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic             locked,
    output logic             err,
    output logic             duty_err,
    output logic             meas_vld,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TOUT_C = CNT_W'(2 * DIV);
    localparam logic [GC_W-1:0]  LOCK_C = GC_W'(LOCK_CNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef DUTY_CHECK_EN
    // Odd ratios cannot split evenly, so either rounding of the high time is accepted.
    function automatic logic duty_ok(input logic [CNT_W-1:0] h);
        if (DIV % 2 == 0)
            return h == CNT_W'(DIV / 2);
        else
            return (h == CNT_W'(DIV / 2)) || (h == CNT_W'(DIV / 2 + 1));
    endfunction
`endif

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] hl_q, hl_d;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             duty_err_q, duty_err_d;
    logic             meas_vld_q, meas_vld_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;

    logic             rise, fall, timeout, dok, good;
    logic [GC_W-1:0]  good_nxt;

    always_comb begin
        s1_d       = div_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        state_d    = state_q;
        hl_d       = hl_q;
        good_cnt_d = good_cnt_q;
        locked_d   = locked_q;
        err_d      = 1'b0;
        duty_err_d = 1'b0;
        meas_vld_d = 1'b0;
        period_d   = period_q;
        high_len_d = high_len_q;

        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;
`ifdef DUTY_CHECK_EN
        dok = duty_ok(hl_q);
`else
        dok = 1'b1;
`endif
        good     = (p_cnt_q == DIV_C) && dok;
        good_nxt = (good_cnt_q >= LOCK_C) ? LOCK_C : good_cnt_q + GC_W'(1);
        p_cnt_d  = rise ? CNT_W'(1) : sat_inc(p_cnt_q);

        // An edge the FSM is waiting for always beats a coincident timeout.
        timeout = (p_cnt_q >= TOUT_C) && !rise && !((state_q == ST_HIGH) && fall);

        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall) begin
                    hl_d    = p_cnt_q;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    period_d   = p_cnt_q;
                    high_len_d = hl_q;
                    meas_vld_d = 1'b1;
                    state_d    = ST_HIGH;
                    if (good) begin
                        good_cnt_d = good_nxt;
                        if (good_nxt == LOCK_C) locked_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        duty_err_d = ~dok;
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reloading the counter makes a stuck input time out again every 2*DIV cycles.
        if (timeout) begin
            err_d      = 1'b1;
            locked_d   = 1'b0;
            good_cnt_d = '0;
            state_d    = ST_IDLE;
            p_cnt_d    = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= ST_IDLE;
            p_cnt_q    <= '0;
            hl_q       <= '0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            duty_err_q <= 1'b0;
            meas_vld_q <= 1'b0;
            period_q   <= '0;
            high_len_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            state_q    <= state_d;
            p_cnt_q    <= p_cnt_d;
            hl_q       <= hl_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            duty_err_q <= duty_err_d;
            meas_vld_q <= meas_vld_d;
            period_q   <= period_d;
            high_len_q <= high_len_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign duty_err = duty_err_q;
    assign meas_vld = meas_vld_q;
    assign period   = period_q;
    assign high_len = high_len_q;

endmodule
